axi_lite_to_reg_bridge: RTL and testbench

AXI_LITE_TO_REG_BRIDGE -- requirements
Module: axi_lite_to_reg_bridge

---
 rtl/axi_lite_to_reg_bridge.sv | 186 ++++++++++++++++++
 tb/tb_axi_lite_to_reg_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_to_reg_bridge.sv
// AXI-Lite slave to simple valid/ready register port bridge.
// One transaction in flight; round-robin read/write arbitration; optional access timeout.
module axi_lite_to_reg_bridge #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic [AddrWidth-1:0]     aw_addr_i,
    input  logic [2:0]               aw_prot_i,
    input  logic                     aw_valid_i,
    output logic                     aw_ready_o,

    input  logic [DataWidth-1:0]     w_data_i,
    input  logic [DataWidth/8-1:0]   w_strb_i,
    input  logic                     w_valid_i,
    output logic                     w_ready_o,

    output logic [1:0]               b_resp_o,
    output logic                     b_valid_o,
    input  logic                     b_ready_i,

    input  logic [AddrWidth-1:0]     ar_addr_i,
    input  logic [2:0]               ar_prot_i,
    input  logic                     ar_valid_i,
    output logic                     ar_ready_o,

    output logic [DataWidth-1:0]     r_data_o,
    output logic [1:0]               r_resp_o,
    output logic                     r_valid_o,
    input  logic                     r_ready_i,

    output logic [AddrWidth-1:0]     reg_addr_o,
    output logic                     reg_write_o,
    output logic [DataWidth-1:0]     reg_wdata_o,
    output logic [DataWidth/8-1:0]   reg_wstrb_o,
    output logic                     reg_valid_o,
    input  logic                     reg_ready_i,
    input  logic [DataWidth-1:0]     reg_rdata_i,
    input  logic                     reg_error_i
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    localparam logic [CntWidth-1:0] CntLast =
        (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;
    localparam logic [CntWidth-1:0] CntMax = '1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StRespB  = 2'd2;
    localparam logic [1:0] StRespR  = 2'd3;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    logic [1:0]           state_q, state_d;
    logic                 prio_q, prio_d;      // 0: favour write, 1: favour read
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 write_q, write_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [StrbWidth-1:0] wstrb_q, wstrb_d;
    logic [1:0]           resp_q, resp_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    logic wr_elig, rd_elig;
    logic grant_wr, grant_rd;
    logic is_idle;
    logic timeout_hit;
    logic unused_prot;

    assign unused_prot = ^{aw_prot_i, ar_prot_i};

    assign wr_elig  = aw_valid_i & w_valid_i;
    assign rd_elig  = ar_valid_i;
    assign grant_wr = wr_elig & (~rd_elig | ~prio_q);
    assign grant_rd = rd_elig & (~wr_elig |  prio_q);

    // NOTE: readies are combinational from inputs, so they are gated with rst_ni
    // to stay low while reset is held even though the state already reads IDLE.
    assign is_idle     = rst_ni & (state_q == StIdle);
    assign timeout_hit = (TimeoutCycles > 0) && (cnt_q == CntLast);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        resp_d  = resp_q;
        rdata_d = rdata_q;

        case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    addr_d  = aw_addr_i;
                    write_d = 1'b1;
                    wdata_d = w_data_i;
                    wstrb_d = w_strb_i;
                    prio_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StAccess;
                end else if (grant_rd) begin
                    addr_d  = ar_addr_i;
                    write_d = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    prio_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                // A ready arriving on the last allowed cycle wins over the timeout.
                if (reg_ready_i) begin
                    rdata_d = reg_rdata_i;
                    resp_d  = reg_error_i ? RespSlvErr : RespOkay;
                    state_d = write_q ? StRespB : StRespR;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    resp_d  = RespDecErr;
                    state_d = write_q ? StRespB : StRespR;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StRespB: begin
                if (b_ready_i) state_d = StIdle;
            end
            StRespR: begin
                if (r_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            resp_q  <= RespOkay;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    assign aw_ready_o  = is_idle & grant_wr;
    assign w_ready_o   = is_idle & grant_wr;
    assign ar_ready_o  = is_idle & grant_rd;

    assign reg_valid_o = (state_q == StAccess);
    assign reg_addr_o  = addr_q;
    assign reg_write_o = write_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = wstrb_q;

    assign b_valid_o   = (state_q == StRespB);
    assign b_resp_o    = resp_q;
    assign r_valid_o   = (state_q == StRespR);
    assign r_resp_o    = resp_q;
    assign r_data_o    = rdata_q;

endmodule

// File: tb/tb_axi_lite_to_reg_bridge.sv
// Directed bench for axi_lite_to_reg_bridge: a table of single transactions
// plus hand-written sequences for arbitration, channel pairing, stalls and reset.
module tb_axi_lite_to_reg_bridge;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] aw_addr_i;
    logic [2:0]  aw_prot_i;
    logic        aw_valid_i;
    logic        aw_ready_o;
    logic [31:0] w_data_i;
    logic [3:0]  w_strb_i;
    logic        w_valid_i;
    logic        w_ready_o;
    logic [1:0]  b_resp_o;
    logic        b_valid_o;
    logic        b_ready_i;
    logic [31:0] ar_addr_i;
    logic [2:0]  ar_prot_i;
    logic        ar_valid_i;
    logic        ar_ready_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_valid_o;
    logic        r_ready_i;
    logic [31:0] reg_addr_o;
    logic        reg_write_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_valid_o;
    logic        reg_ready_i;
    logic [31:0] reg_rdata_i;
    logic        reg_error_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          delay;     // ACCESS cycles with reg_ready low before it rises
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    axi_lite_to_reg_bridge #(
        .AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_addr_i(aw_addr_i), .aw_prot_i(aw_prot_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_addr_i(ar_addr_i), .ar_prot_i(ar_prot_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o), .reg_wdata_o(reg_wdata_o),
        .reg_wstrb_o(reg_wstrb_o), .reg_valid_o(reg_valid_o), .reg_ready_i(reg_ready_i),
        .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts and ends shortly after a falling edge with the DUT in IDLE.
    task automatic txn(input vec_t v);
        int n;
        int hi;
        logic stable;
        n = (v.delay < TO) ? v.delay + 1 : TO;
        if (v.is_wr) begin
            aw_addr_i = v.addr; w_data_i = v.wdata; w_strb_i = v.strb;
            aw_valid_i = 1'b1; w_valid_i = 1'b1;
        end else begin
            ar_addr_i = v.addr; ar_valid_i = 1'b1;
        end
        #1;
        check("grant", {aw_ready_o, w_ready_o, ar_ready_o}, v.is_wr ? 3'b110 : 3'b001);
        @(negedge clk_i);
        aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
        hi = 0;
        stable = 1'b1;
        for (int k = 0; k < n; k++) begin
            reg_ready_i = (k == v.delay);
            reg_rdata_i = v.rdata;
            reg_error_i = v.err;
            #1;
            if (reg_valid_o) hi++;
            if (reg_addr_o !== v.addr || reg_write_o !== v.is_wr ||
                reg_wdata_o !== (v.is_wr ? v.wdata : 32'h0) ||
                reg_wstrb_o !== (v.is_wr ? v.strb : 4'h0) ||
                aw_ready_o || w_ready_o || ar_ready_o) stable = 1'b0;
            @(negedge clk_i);
        end
        reg_ready_i = 1'b0; reg_error_i = 1'b0;
        #1;
        check("acc_len", hi, n);
        check("acc_req", stable, 1'b1);
        if (v.is_wr) begin
            check("b_valid", {b_valid_o, r_valid_o, reg_valid_o}, 3'b100);
            check("b_resp", b_resp_o, v.exp_resp);
            b_ready_i = 1'b1;
        end else begin
            check("r_valid", {b_valid_o, r_valid_o, reg_valid_o}, 3'b010);
            check("r_resp", r_resp_o, v.exp_resp);
            check("r_data", r_data_o, v.exp_data);
            r_ready_i = 1'b1;
        end
        @(negedge clk_i);
        b_ready_i = 1'b0; r_ready_i = 1'b0;
        #1;
        check("resp_done", {b_valid_o, r_valid_o, reg_valid_o}, 3'b000);
    endtask

    initial begin : main
        int grants;
        vecs[0] = '{1'b0, 32'h10, 32'h0,    4'h0, 0,  32'hDEADBEEF, 1'b0, 2'b00, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 32'h4,  32'h1234, 4'hF, 0,  32'h0,        1'b0, 2'b00, 32'h0};
        vecs[2] = '{1'b1, 32'h8,  32'hAA,   4'h0, 2,  32'h0,        1'b0, 2'b00, 32'h0};
        vecs[3] = '{1'b0, 32'h14, 32'h0,    4'h0, 3,  32'h55,       1'b1, 2'b10, 32'h55};
        vecs[4] = '{1'b1, 32'h18, 32'h77,   4'h5, 15, 32'h0,        1'b0, 2'b00, 32'h0};
        vecs[5] = '{1'b1, 32'h1C, 32'h99,   4'hA, 16, 32'h0,        1'b0, 2'b11, 32'h0};
        vecs[6] = '{1'b0, 32'h24, 32'h0,    4'h0, 20, 32'hFFFF0000, 1'b0, 2'b11, 32'h0};
        vecs[7] = '{1'b1, 32'h28, 32'h5A5A, 4'hC, 1,  32'h0,        1'b1, 2'b10, 32'h0};

        // Reset with every request asserted: nothing may be accepted.
        rst_ni = 1'b0;
        aw_addr_i = 32'h4; aw_prot_i = 3'b010; w_data_i = 32'h1234; w_strb_i = 4'hF;
        ar_addr_i = 32'h10; ar_prot_i = 3'b101;
        aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
        b_ready_i = 1'b0; r_ready_i = 1'b0;
        reg_ready_i = 1'b1; reg_rdata_i = 32'hDEADBEEF; reg_error_i = 1'b0;
        #2;
        check("rst_ready", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b000);
        check("rst_valid", {reg_valid_o, b_valid_o, r_valid_o}, 3'b000);
        check("rst_data", {reg_addr_o, reg_wdata_o}, 64'h0);
        check("rst_out", {r_data_o, reg_wstrb_o, reg_write_o, b_resp_o, r_resp_o}, 64'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Back-to-back contention: grants must alternate starting with write.
        b_ready_i = 1'b1; r_ready_i = 1'b1;
        grants = 0;
        for (int c = 0; c < 30; c++) begin
            if (grants == 8) begin
                aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
            end
            #1;
            if (aw_ready_o || ar_ready_o) begin
                check("arb_order", {aw_ready_o, w_ready_o, ar_ready_o},
                      (grants % 2 == 0) ? 3'b110 : 3'b001);
                grants++;
            end
            @(negedge clk_i);
        end
        check("arb_count", grants, 8);
        aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
        b_ready_i = 1'b0; r_ready_i = 1'b0; reg_ready_i = 1'b0;
        #1;
        check("arb_idle", {reg_valid_o, b_valid_o, r_valid_o}, 3'b000);

        for (int i = 0; i < 8; i++) txn(vecs[i]);

        // AW without W is never accepted on its own.
        aw_addr_i = 32'h30; aw_valid_i = 1'b1; w_valid_i = 1'b0;
        w_data_i = 32'hF00D; w_strb_i = 4'h3;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("aw_alone", {aw_ready_o, w_ready_o, reg_valid_o}, 3'b000);
            @(negedge clk_i);
        end
        w_valid_i = 1'b1;
        #1;
        check("aw_w_pair", {aw_ready_o, w_ready_o}, 2'b11);
        @(negedge clk_i);
        aw_valid_i = 1'b0; w_valid_i = 1'b0; reg_ready_i = 1'b1;
        #1;
        check("aw_w_req", {reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o[15:0]}, {2'b11, 32'h30, 16'hF00D});
        @(negedge clk_i);
        reg_ready_i = 1'b0;
        #1;
        check("aw_w_resp", {b_valid_o, b_resp_o}, 3'b100);
        b_ready_i = 1'b1;
        @(negedge clk_i);
        b_ready_i = 1'b0;

        // SLVERR response held while b_ready is low; pending read is stalled.
        aw_addr_i = 32'hC; w_data_i = 32'hCAFE; w_strb_i = 4'h3;
        aw_valid_i = 1'b1; w_valid_i = 1'b1;
        #1;
        check("err_grant", {aw_ready_o, w_ready_o}, 2'b11);
        @(negedge clk_i);
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        ar_addr_i = 32'h20; ar_valid_i = 1'b1;
        reg_ready_i = 1'b1; reg_error_i = 1'b1;
        #1;
        check("err_acc_ar", ar_ready_o, 1'b0);
        @(negedge clk_i);
        reg_ready_i = 1'b0; reg_error_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("err_hold", {b_valid_o, b_resp_o, ar_ready_o}, 4'b1100);
            @(negedge clk_i);
        end
        b_ready_i = 1'b1;
        #1;
        check("err_last", {b_valid_o, b_resp_o}, 3'b110);
        @(negedge clk_i);
        b_ready_i = 1'b0;
        #1;
        check("err_then_ar", {b_valid_o, ar_ready_o}, 2'b01);
        @(negedge clk_i);
        ar_valid_i = 1'b0; reg_ready_i = 1'b1; reg_rdata_i = 32'h600D;
        #1;
        check("err_rd_req", {reg_valid_o, reg_write_o, reg_addr_o}, {2'b10, 32'h20});
        @(negedge clk_i);
        reg_ready_i = 1'b0;
        #1;
        check("err_rd_resp", {r_valid_o, r_resp_o, r_data_o}, {3'b100, 32'h600D});
        r_ready_i = 1'b1;
        @(negedge clk_i);
        r_ready_i = 1'b0;

        // Reset in the middle of an access drops it without a response.
        ar_addr_i = 32'h40; ar_valid_i = 1'b1;
        #1;
        check("rst_acc_grant", ar_ready_o, 1'b1);
        @(negedge clk_i);
        ar_valid_i = 1'b0; reg_ready_i = 1'b0;
        #1;
        check("rst_acc_busy", reg_valid_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("rst_acc_drop", {reg_valid_o, b_valid_o, r_valid_o, reg_addr_o}, 35'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check("rst_acc_quiet", {reg_valid_o, b_valid_o, r_valid_o}, 3'b000);
        txn('{1'b0, 32'h44, 32'h0, 4'h0, 1, 32'h12345678, 1'b0, 2'b00, 32'h12345678});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
